// File: rtl/fft_stage_ctrl_if.sv
// Bus between the FFT stage controller and its frame control, butterfly and
// memory neighbours. The controller side uses the master modport.
interface fft_stage_ctrl_if #(
  parameter int AW = 5,
  parameter int SW = 4
);
  // Handshake: bf_valid_in marks a block issued this cycle and cannot be
  // refused by the butterfly; stall holds issue and is the only backpressure.
  // bf_valid_out is one result per issued block, in issue order, and is
  // accepted in its cycle (wr_en) unless it has no matching issued block.
  logic          start;
  logic          stall;
  logic          bf_valid_out;
  logic          bf_valid_in;
  logic [AW-1:0] rd_blk_addr;
  logic [AW-1:0] wr_blk_addr;
  logic          wr_en;
  logic [SW-1:0] stage;
  logic [AW-1:0] tw_base;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   perf_stall_cnt;
  logic [1:0]    dbg_state;

  modport master (
    input  start, stall, bf_valid_out,
    output bf_valid_in, rd_blk_addr, wr_blk_addr, wr_en, stage, tw_base,
           busy, done, err, perf_stall_cnt, dbg_state
  );

  modport slave (
    output start, stall, bf_valid_out,
    input  bf_valid_in, rd_blk_addr, wr_blk_addr, wr_en, stage, tw_base,
           busy, done, err, perf_stall_cnt, dbg_state
  );
endinterface

// File: rtl/fft_stage_ctrl.sv
// Stage sequencer for a 16-lane radix-2 butterfly over a 512-point FFT.
// Optional stall counter enabled with FFT_STAGE_CTRL_PERF_EN.
module fft_stage_ctrl #(
  parameter int DATA   = 512,
  parameter int NUM    = 16,
  parameter int STAGES = 9
) (
  input logic               clk,
  input logic               rst,
  fft_stage_ctrl_if.master  bus
);
  localparam int BLKS = DATA / NUM;
  localparam int AW   = $clog2(BLKS);
  localparam int SW   = $clog2(STAGES);
  localparam int FW   = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [AW-1:0] issue_cnt_q;
  logic [AW-1:0] ret_cnt_q;
  logic [FW-1:0] infl_q;
  logic [FW-1:0] infl_d;
  logic [SW-1:0] stage_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic issue;
  logic accept;
  logic spurious;
  logic last_issue;
  logic last_ret;
  logic start_ok;

  assign issue      = (state_q == ISSUE) && !bus.stall;
  // A return needs a matching block still inside the butterfly.
  assign accept     = bus.bf_valid_out && ((state_q == ISSUE) || (state_q == DRAIN))
                      && (infl_q != '0);
  assign spurious   = bus.bf_valid_out && !accept;
  assign last_issue = issue && (issue_cnt_q == AW'(BLKS - 1));
  assign last_ret   = accept && (state_q == DRAIN) && (ret_cnt_q == AW'(BLKS - 1));
  assign start_ok   = (state_q == IDLE) && bus.start;

  always_comb begin
    infl_d = infl_q;
    case ({issue, accept})
      2'b10:   infl_d = infl_q + FW'(1);
      2'b01:   infl_d = infl_q - FW'(1);
      default: infl_d = infl_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      infl_q      <= '0;
      stage_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // A spurious return on the start cycle still counts against the new frame.
      if (start_ok) begin
        err_q <= spurious;
      end else if (spurious) begin
        err_q <= 1'b1;
      end

      if (issue) begin
        issue_cnt_q <= issue_cnt_q + AW'(1);
      end
      if (accept) begin
        ret_cnt_q <= ret_cnt_q + AW'(1);
      end
      infl_q <= infl_d;

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q     <= ISSUE;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            infl_q      <= '0;
            stage_q     <= '0;
            busy_q      <= 1'b1;
          end
        end
        ISSUE: begin
          if (last_issue) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_ret) begin
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            infl_q      <= '0;
            if (stage_q == SW'(STAGES - 1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ISSUE;
              stage_q <= stage_q + SW'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FFT_STAGE_CTRL_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (start_ok) begin
      perf_q <= '0;
    end else if ((state_q == ISSUE) && bus.stall && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign bus.perf_stall_cnt = perf_q;
`else
  assign bus.perf_stall_cnt = 16'd0;
`endif

  assign bus.bf_valid_in = issue;
  assign bus.rd_blk_addr = issue_cnt_q;
  assign bus.wr_en       = accept;
  assign bus.wr_blk_addr = ret_cnt_q;
  assign bus.stage       = stage_q;
  // Shifting within AW bits gives the modulo-BLKS twiddle index for free.
  assign bus.tw_base     = issue_cnt_q << stage_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl with a fixed-latency butterfly model.
module tb_fft_stage_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_stage_ctrl_if bus ();

  fft_stage_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] pipe;

  int r_done_cyc, r_done_cnt, r_vin_cnt, r_rd_bad, r_wr_bad, r_hold_bad;
  int r_err_seen, r_post_busy, r_post_stage, r_stall_seen;

  // Runs a frame starting now (start in cycle 0); the bench sits 1 time unit
  // after a rising edge between cycles. Stops one cycle after done or at max_cyc.
  task automatic run_frame(input int lat, input int st_stage, input int st_blk,
                           input int st_len, input int mid_stage, input int max_cyc);
    int exp_rd = 0;
    int exp_stg = 0;
    int exp_wr = 0;
    int exp_wstg = 0;
    int stall_left = st_len;
    r_done_cyc = -1; r_done_cnt = 0; r_vin_cnt = 0; r_rd_bad = 0; r_wr_bad = 0;
    r_hold_bad = 0; r_err_seen = 0; r_post_busy = -1; r_post_stage = -1; r_stall_seen = 0;
    pipe = '0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      bus.start = (cyc == 0) || (mid_stage >= 0 && exp_stg == mid_stage && exp_rd == 5);
      bus.stall = 1'b0;
      if (stall_left > 0 && exp_stg == st_stage && exp_rd == st_blk) begin
        bus.stall = 1'b1;
        stall_left--;
        r_stall_seen++;
      end
      bus.bf_valid_out = pipe[lat-1];
      #1;
      if (bus.stall && (bus.bf_valid_in !== 1'b0 || bus.rd_blk_addr !== 5'(st_blk))) r_hold_bad++;
      if (bus.bf_valid_in === 1'b1) begin
        r_vin_cnt++;
        if (bus.rd_blk_addr !== 5'(exp_rd) || bus.stage !== 4'(exp_stg) ||
            bus.tw_base !== 5'(exp_rd << exp_stg)) r_rd_bad++;
        exp_rd++;
        if (exp_rd == 32) begin exp_rd = 0; exp_stg++; end
      end
      if (bus.bf_valid_out === 1'b1) begin
        if (bus.wr_en !== 1'b1 || bus.wr_blk_addr !== 5'(exp_wr) || bus.stage !== 4'(exp_wstg))
          r_wr_bad++;
        exp_wr++;
        if (exp_wr == 32) begin exp_wr = 0; exp_wstg++; end
      end else if (bus.wr_en !== 1'b0) begin
        r_wr_bad++;
      end
      if (cyc > 0 && bus.err !== 1'b0) r_err_seen = 1;
      if (bus.done === 1'b1) begin
        r_done_cnt++;
        if (r_done_cyc < 0) r_done_cyc = cyc;
      end
      if (r_done_cyc >= 0 && cyc == r_done_cyc + 1) begin
        r_post_busy  = bus.busy;
        r_post_stage = bus.stage;
      end
      pipe = {pipe[6:0], bus.bf_valid_in};
      @(posedge clk); #1;
      if (r_done_cyc >= 0 && cyc == r_done_cyc + 1) break;
    end
    bus.start = 1'b0; bus.stall = 1'b0; bus.bf_valid_out = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.stall = 1'b0; bus.bf_valid_out = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.bf_valid_in !== 1'b0) begin bad++; $display("FAIL reset_vin got=%b want=0", bus.bf_valid_in); end
    total++; if (bus.rd_blk_addr !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d want=0", bus.rd_blk_addr); end
    total++; if (bus.wr_blk_addr !== 5'd0) begin bad++; $display("FAIL reset_wr got=%0d want=0", bus.wr_blk_addr); end
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", bus.wr_en); end
    total++; if (bus.stage !== 4'd0) begin bad++; $display("FAIL reset_stage got=%0d want=0", bus.stage); end
    total++; if (bus.tw_base !== 5'd0) begin bad++; $display("FAIL reset_tw got=%0d want=0", bus.tw_base); end
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b want=00", bus.busy, bus.done); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err); end
    total++; if (bus.perf_stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_perf got=%0d want=0", bus.perf_stall_cnt); end
    total++; if (bus.dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", bus.dbg_state); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    run_frame(1, -1, 0, 0, -1, 1000);
    total++; if (r_done_cyc !== 298) begin bad++; $display("FAIL nominal_done_cyc got=%0d want=298", r_done_cyc); end
    total++; if (r_done_cnt !== 1) begin bad++; $display("FAIL nominal_done_cnt got=%0d want=1", r_done_cnt); end
    total++; if (r_vin_cnt !== 288) begin bad++; $display("FAIL nominal_issues got=%0d want=288", r_vin_cnt); end
    total++; if (r_rd_bad !== 0) begin bad++; $display("FAIL nominal_rd_seq got=%0d want=0", r_rd_bad); end
    total++; if (r_wr_bad !== 0) begin bad++; $display("FAIL nominal_wr_seq got=%0d want=0", r_wr_bad); end
    total++; if (r_err_seen !== 0) begin bad++; $display("FAIL nominal_err got=%0d want=0", r_err_seen); end
    total++; if (r_post_busy !== 0) begin bad++; $display("FAIL nominal_post_busy got=%0d want=0", r_post_busy); end
    total++; if (r_post_stage !== 8) begin bad++; $display("FAIL nominal_post_stage got=%0d want=8", r_post_stage); end
    total++; if (bus.perf_stall_cnt !== 16'd0) begin bad++; $display("FAIL nominal_perf got=%0d want=0", bus.perf_stall_cnt); end
  endtask

  task automatic test_stall();
    logic [15:0] want_perf;
`ifdef FFT_STAGE_CTRL_PERF_EN
    want_perf = 16'd5;
`else
    want_perf = 16'd0;
`endif
    run_frame(1, 2, 10, 5, -1, 1000);
    total++; if (r_stall_seen !== 5) begin bad++; $display("FAIL stall_cycles got=%0d want=5", r_stall_seen); end
    total++; if (r_hold_bad !== 0) begin bad++; $display("FAIL stall_hold got=%0d want=0", r_hold_bad); end
    total++; if (r_done_cyc !== 303) begin bad++; $display("FAIL stall_done_cyc got=%0d want=303", r_done_cyc); end
    total++; if (r_vin_cnt !== 288 || r_rd_bad !== 0) begin bad++; $display("FAIL stall_rd_seq got=%0d/%0d want=288/0", r_vin_cnt, r_rd_bad); end
    total++; if (bus.perf_stall_cnt !== want_perf) begin bad++; $display("FAIL stall_perf got=%0d want=%0d", bus.perf_stall_cnt, want_perf); end
  endtask

  task automatic test_latency4();
    run_frame(4, -1, 0, 0, -1, 1000);
    total++; if (r_done_cyc !== 325) begin bad++; $display("FAIL lat4_done_cyc got=%0d want=325", r_done_cyc); end
    total++; if (r_wr_bad !== 0) begin bad++; $display("FAIL lat4_wr_seq got=%0d want=0", r_wr_bad); end
    total++; if (r_rd_bad !== 0 || r_err_seen !== 0) begin bad++; $display("FAIL lat4_rd_err got=%0d/%0d want=0/0", r_rd_bad, r_err_seen); end
  endtask

  task automatic test_start_ignored();
    run_frame(1, -1, 0, 0, 3, 1000);
    total++; if (r_done_cyc !== 298) begin bad++; $display("FAIL midstart_done_cyc got=%0d want=298", r_done_cyc); end
    total++; if (r_rd_bad !== 0 || r_wr_bad !== 0) begin bad++; $display("FAIL midstart_seq got=%0d/%0d want=0/0", r_rd_bad, r_wr_bad); end
  endtask

  task automatic test_spurious();
    bus.bf_valid_out = 1'b1;
    #1;
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL spurious_wr_en got=%b want=0", bus.wr_en); end
    @(posedge clk); #1;
    bus.bf_valid_out = 1'b0;
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL spurious_err got=%b want=1", bus.err); end
    total++; if (bus.wr_blk_addr !== 5'd0) begin bad++; $display("FAIL spurious_wr_cnt got=%0d want=0", bus.wr_blk_addr); end
    run_frame(1, -1, 0, 0, -1, 1000);
    total++; if (r_err_seen !== 0) begin bad++; $display("FAIL spurious_err_clear got=%0d want=0", r_err_seen); end
  endtask

  task automatic test_reset_mid();
    run_frame(1, -1, 0, 0, -1, 180);
    total++; if (bus.stage !== 4'd5) begin bad++; $display("FAIL midrst_pre_stage got=%0d want=5", bus.stage); end
    rst = 1'b1;
    #1;
    total++; if (bus.stage !== 4'd0 || bus.busy !== 1'b0 || bus.bf_valid_in !== 1'b0 || bus.rd_blk_addr !== 5'd0)
      begin bad++; $display("FAIL midrst_outputs got=%0d/%b/%b/%0d want=0/0/0/0", bus.stage, bus.busy, bus.bf_valid_in, bus.rd_blk_addr); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(1, -1, 0, 0, -1, 1000);
    total++; if (r_done_cyc !== 298) begin bad++; $display("FAIL midrst_done_cyc got=%0d want=298", r_done_cyc); end
    total++; if (r_vin_cnt !== 288 || r_rd_bad !== 0) begin bad++; $display("FAIL midrst_rd_seq got=%0d/%0d want=288/0", r_vin_cnt, r_rd_bad); end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.stall = 1'b0; bus.bf_valid_out = 1'b0;
    test_reset();
    test_nominal();
    test_stall();
    test_latency4();
    test_start_ignored();
    test_spurious();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
